serial2parallel_in: RTL and testbench

Byte-serial operand collector for the 64-bit signed divider datapath: accepts a 16-byte frame (dividend then divisor, each LSB-first) over an 8-bit valid/ready stream, assembles two 65-bit sign-magnitude operands and presents them to the divider core with a valid/ready handshake. It is the input-side mirror of the output serialiser, which consumes the divider's 65-bit result in the same `{sign, magnitude[63:0]}` format. Backpressure from the divider stalls the byte stream; a dedicated flush discards a partial frame.

---
 rtl/serial2parallel_in_if.sv | 23 ++
 rtl/serial2parallel_in.sv | 85 ++++++++
 tb/tb_serial2parallel_in.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/serial2parallel_in_if.sv
// Byte stream in, operand pair out: the handshake bundle between the byte source,
// the operand collector and the divider core.
interface serial2parallel_in_if;
    logic        in_valid;
    logic [7:0]  data_i;
    logic        sign_i;
    logic        in_ready;
    logic [64:0] dividend_o;
    logic [64:0] divisor_o;
    logic        div_zero;
    logic        op_valid;
    logic        op_ready;

    modport master (
        output in_valid, data_i, sign_i, op_ready,
        input  in_ready, dividend_o, divisor_o, div_zero, op_valid
    );

    modport slave (
        input  in_valid, data_i, sign_i, op_ready,
        output in_ready, dividend_o, divisor_o, div_zero, op_valid
    );
endinterface

// File: rtl/serial2parallel_in.sv
// Collects a 16-byte frame (dividend then divisor, LSB-first) into two 65-bit
// {sign, magnitude} operands and presents them to the divider with valid/ready.
module serial2parallel_in (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    serial2parallel_in_if.slave   bus
);

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        HOLD   = 2'd2
    } state_t;

    state_t      state;
    logic [2:0]  cnt;
    logic [63:0] mag_a;
    logic [63:0] mag_b;
    logic        sign_a;
    logic        sign_b;
    logic        div_zero_q;
    logic [63:0] mag_b_next;
    logic        take;

    assign take       = bus.in_valid && (state != HOLD);
    assign mag_b_next = {bus.data_i, mag_b[63:8]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= LOAD_A;
            cnt        <= '0;
            mag_a      <= '0;
            mag_b      <= '0;
            sign_a     <= 1'b0;
            sign_b     <= 1'b0;
            div_zero_q <= 1'b0;
        end else if (flush) begin
            // Operand registers are left alone; the next frame overwrites them.
            state      <= LOAD_A;
            cnt        <= '0;
            div_zero_q <= 1'b0;
        end else begin
            case (state)
                LOAD_A: begin
                    if (take) begin
                        mag_a <= {bus.data_i, mag_a[63:8]};
                        if (cnt == 3'd0) sign_a <= bus.sign_i;
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) state <= LOAD_B;
                    end
                end
                LOAD_B: begin
                    if (take) begin
                        mag_b <= mag_b_next;
                        if (cnt == 3'd0) sign_b <= bus.sign_i;
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            state      <= HOLD;
                            div_zero_q <= (mag_b_next == '0);
                        end
                    end
                end
                HOLD: begin
                    if (bus.op_ready) begin
                        state      <= LOAD_A;
                        cnt        <= '0;
                        div_zero_q <= 1'b0;
                    end
                end
                default: begin
                    state <= LOAD_A;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign bus.in_ready   = (state != HOLD);
    assign bus.op_valid   = (state == HOLD);
    assign bus.div_zero   = div_zero_q;
    assign bus.dividend_o = {sign_a, mag_a};
    assign bus.divisor_o  = {sign_b, mag_b};

endmodule

// File: tb/tb_serial2parallel_in.sv
// Directed bench for the byte-serial operand collector: table of whole frames
// plus hand-written backpressure, flush and async-reset sequences.
module tb_serial2parallel_in;

    logic clk;
    logic rst_n;
    logic flush;

    serial2parallel_in_if bus ();

    serial2parallel_in dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] a;
        logic        sa;
        logic [63:0] b;
        logic        sb;
        bit          gapped;
        logic [64:0] exp_dvd;
        logic [64:0] exp_dvs;
        logic        exp_dz;
    } vec_t;

    vec_t vecs [5];
    int   nvec;
    int   nerr;

    task automatic check(input string name, input logic [64:0] act, input logic [64:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic s);
        bus.in_valid = 1'b1;
        bus.data_i   = d;
        bus.sign_i   = s;
        tick();
        bus.in_valid = 1'b0;
        bus.data_i   = 8'hEE;
        bus.sign_i   = 1'b1;
    endtask

    task automatic run_frame(input logic [63:0] a, input logic sa,
                             input logic [63:0] b, input logic sb, input bit gapped);
        logic [7:0] d;
        logic       s;
        for (int i = 0; i < 16; i++) begin
            d = (i < 8) ? a[i*8 +: 8] : b[(i-8)*8 +: 8];
            s = (i == 0) ? sa : ((i == 8) ? sb : ~sa);
            send_byte(d, s);
            if (gapped && i < 15) tick();
        end
    endtask

    task automatic send_partial(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) send_byte(base + 8'(i), 1'b1);
    endtask

    initial begin
        nvec = 0;
        nerr = 0;

        vecs[0] = '{64'h0807060504030201, 1'b1, 64'h100F0E0D0C0B0A09, 1'b0, 1'b0,
                    65'h1_0807060504030201, 65'h0_100F0E0D0C0B0A09, 1'b0};
        vecs[1] = '{64'h0807060504030201, 1'b1, 64'h100F0E0D0C0B0A09, 1'b0, 1'b1,
                    65'h1_0807060504030201, 65'h0_100F0E0D0C0B0A09, 1'b0};
        vecs[2] = '{64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h0000000000000000, 1'b1, 1'b0,
                    65'h0_FFFFFFFFFFFFFFFF, 65'h1_0000000000000000, 1'b1};
        vecs[3] = '{64'h0000000000000000, 1'b1, 64'h0000000000000001, 1'b1, 1'b1,
                    65'h1_0000000000000000, 65'h1_0000000000000001, 1'b0};
        vecs[4] = '{64'h123456789ABCDEF0, 1'b0, 64'h8000000000000000, 1'b0, 1'b0,
                    65'h0_123456789ABCDEF0, 65'h0_8000000000000000, 1'b0};

        rst_n        = 1'b0;
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        bus.data_i   = 8'h00;
        bus.sign_i   = 1'b0;
        bus.op_ready = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        check("reset_dividend", bus.dividend_o, 65'h0);
        check("reset_divisor",  bus.divisor_o,  65'h0);
        check("reset_div_zero", 65'(bus.div_zero), 65'h0);
        check("reset_op_valid", 65'(bus.op_valid), 65'h0);
        check("reset_in_ready", 65'(bus.in_ready), 65'h1);

        // Table frames, op_ready tied high: one HOLD cycle per frame.
        for (int v = 0; v < 5; v++) begin
            run_frame(vecs[v].a, vecs[v].sa, vecs[v].b, vecs[v].sb, vecs[v].gapped);
            check($sformatf("v%0d_op_valid", v), 65'(bus.op_valid), 65'h1);
            check($sformatf("v%0d_in_ready", v), 65'(bus.in_ready), 65'h0);
            check($sformatf("v%0d_dividend", v), bus.dividend_o, vecs[v].exp_dvd);
            check($sformatf("v%0d_divisor", v),  bus.divisor_o,  vecs[v].exp_dvs);
            check($sformatf("v%0d_div_zero", v), 65'(bus.div_zero), 65'(vecs[v].exp_dz));
            tick();
            check($sformatf("v%0d_op_valid_drop", v), 65'(bus.op_valid), 65'h0);
            check($sformatf("v%0d_in_ready_back", v), 65'(bus.in_ready), 65'h1);
        end

        // Backpressure: five HOLD cycles with a byte offered that must not be taken.
        bus.op_ready = 1'b0;
        run_frame(64'h0807060504030201, 1'b1, 64'h100F0E0D0C0B0A09, 1'b0, 1'b0);
        for (int c = 0; c < 5; c++) begin
            check($sformatf("bp%0d_op_valid", c), 65'(bus.op_valid), 65'h1);
            check($sformatf("bp%0d_in_ready", c), 65'(bus.in_ready), 65'h0);
            check($sformatf("bp%0d_dividend", c), bus.dividend_o, 65'h1_0807060504030201);
            check($sformatf("bp%0d_divisor", c),  bus.divisor_o,  65'h0_100F0E0D0C0B0A09);
            bus.in_valid = 1'b1;
            bus.data_i   = 8'hAA;
            tick();
        end
        check("bp_after_dividend", bus.dividend_o, 65'h1_0807060504030201);
        check("bp_after_divisor",  bus.divisor_o,  65'h0_100F0E0D0C0B0A09);
        bus.in_valid = 1'b0;
        bus.op_ready = 1'b1;
        tick();
        check("bp_release_op_valid", 65'(bus.op_valid), 65'h0);
        check("bp_release_in_ready", 65'(bus.in_ready), 65'h1);

        // Flush after 11 bytes, with a byte offered in the flush cycle.
        send_partial(11, 8'hA0);
        flush        = 1'b1;
        bus.in_valid = 1'b1;
        bus.data_i   = 8'h55;
        tick();
        flush        = 1'b0;
        bus.in_valid = 1'b0;
        check("flush_op_valid", 65'(bus.op_valid), 65'h0);
        check("flush_in_ready", 65'(bus.in_ready), 65'h1);
        run_frame(64'h123456789ABCDEF0, 1'b0, 64'h8000000000000000, 1'b0, 1'b0);
        check("flush_next_dividend", bus.dividend_o, 65'h0_123456789ABCDEF0);
        check("flush_next_divisor",  bus.divisor_o,  65'h0_8000000000000000);
        check("flush_next_op_valid", 65'(bus.op_valid), 65'h1);
        tick();

        // Flush coinciding with op_ready in HOLD, on a zero-divisor frame.
        run_frame(64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h0, 1'b1, 1'b0);
        check("fh_div_zero_set", 65'(bus.div_zero), 65'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fh_op_valid", 65'(bus.op_valid), 65'h0);
        check("fh_in_ready", 65'(bus.in_ready), 65'h1);
        check("fh_div_zero", 65'(bus.div_zero), 65'h0);

        // Async reset in LOAD_B, asserted between clock edges.
        send_partial(11, 8'h31);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_dividend", bus.dividend_o, 65'h0);
        check("arst_divisor",  bus.divisor_o,  65'h0);
        check("arst_op_valid", 65'(bus.op_valid), 65'h0);
        check("arst_div_zero", 65'(bus.div_zero), 65'h0);
        tick();
        rst_n = 1'b1;
        tick();
        check("arst_in_ready", 65'(bus.in_ready), 65'h1);
        run_frame(64'h0807060504030201, 1'b1, 64'h100F0E0D0C0B0A09, 1'b0, 1'b1);
        check("arst_next_dividend", bus.dividend_o, 65'h1_0807060504030201);
        check("arst_next_divisor",  bus.divisor_o,  65'h0_100F0E0D0C0B0A09);
        check("arst_next_op_valid", 65'(bus.op_valid), 65'h1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
